// File: rtl/nobl_pkg.sv
// Shared definitions for the NoBL SRAM FIFO read path: scheduler state
// encoding, channel count and the default sizing shared with nobl_fifo.
package nobl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int NCH              = 2;
    localparam int CREDITS_DEF      = 8;
    localparam int MAX_INFLIGHT_DEF = 6;
    localparam int GAP_DEF          = 1;
    localparam int CW_DEF           = 4;

    // One-hot strobe vector for a granted channel index.
    function automatic logic [NCH-1:0] ch_onehot(input logic ch);
        logic [NCH-1:0] v;
        if (ch) begin
            v = 2'b10;
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

endpackage

// File: rtl/nobl_credit_ctr.sv
// Saturating up/down counter. An increment at MAX or a decrement at zero
// raises a one-cycle error pulse; a simultaneous increment and decrement
// always leaves the count unchanged.
module nobl_credit_ctr #(
    parameter int W    = 4,
    parameter int MAX  = 8,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf,
    output logic         o_unf
);

    localparam logic [W-1:0] LP_MAX  = W'(MAX);
    localparam logic [W-1:0] LP_INIT = W'(INIT);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_ovf;
    logic         w_unf;

    // Next count with saturation at both ends.
    always_comb begin
        w_ovf     = i_inc && (r_cnt == LP_MAX);
        w_unf     = i_dec && (r_cnt == {W{1'b0}});
        w_cnt_nxt = r_cnt;
        if (i_inc && !i_dec && !w_ovf) begin
            w_cnt_nxt = r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else if (i_dec && !i_inc && !w_unf) begin
            w_cnt_nxt = r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= LP_INIT;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = w_ovf;
    assign o_unf = w_unf;

endmodule

// File: rtl/nobl_rd_sched.sv
// Credit-based round-robin read scheduler for the dual-channel NoBL SRAM
// FIFO. A read strobe is only raised when the target downstream buffer has a
// free credit and the in-flight limit has room; each accepted read is
// followed by GAP idle cycles to leave SRAM write slots.
// Optional: define NOBL_RD_SCHED_STATS_EN for per-channel accepted-read
// counters (i_stat_clr, o_stat_rd_0, o_stat_rd_1).
module nobl_rd_sched
    import nobl_pkg::*;
#(
    parameter int CREDITS      = CREDITS_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int GAP          = GAP_DEF,
    parameter int CW           = CW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [NCH-1:0]    i_fifo_nonempty,
    input  logic [NCH-1:0]    i_rd_accept,
    input  logic [NCH-1:0]    i_rd_valid,
    input  logic [NCH-1:0]    i_dn_pop,
`ifdef NOBL_RD_SCHED_STATS_EN
    input  logic              i_stat_clr,
    output logic [31:0]       o_stat_rd_0,
    output logic [31:0]       o_stat_rd_1,
`endif
    output logic [NCH-1:0]    o_read_strobe,
    output logic [NCH*CW-1:0] o_credits,
    output logic [CW-1:0]     o_inflight,
    output logic              o_err
);

    localparam logic [CW-1:0] LP_MAX_INFL = CW'(MAX_INFLIGHT);

    state_e         r_state;
    state_e         w_state_nxt;
    logic           r_gnt;
    logic           w_gnt_nxt;
    logic           r_last_gnt;
    logic [1:0]     r_gap_cnt;
    logic [1:0]     w_gap_cnt_nxt;
    logic           r_err;

    logic [CW-1:0]  w_cred [NCH];
    logic [NCH-1:0] w_cred_ovf;
    logic [NCH-1:0] w_cred_unf;
    logic [CW-1:0]  w_inflight;
    logic           w_infl_ovf;
    logic           w_infl_unf;

    logic [NCH-1:0] w_strobe;
    logic [NCH-1:0] w_acc;
    logic [NCH-1:0] w_spur;
    logic [NCH-1:0] w_elig;
    logic           w_any_acc;

    // Strobe is a pure decode of registered state; accepts only count when
    // they land on the strobed channel.
    always_comb begin
        if (r_state == ST_ISSUE) begin
            w_strobe = ch_onehot(r_gnt);
        end else begin
            w_strobe = 2'b00;
        end
        w_acc     = w_strobe & i_rd_accept;
        w_spur    = i_rd_accept & ~w_strobe;
        w_any_acc = |w_acc;
    end

    // Per-channel eligibility from registered counters.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_elig[c] = i_en && i_fifo_nonempty[c] && (w_cred[c] != {CW{1'b0}})
                        && (w_inflight < LP_MAX_INFL);
        end
    end

    // Free-credit counter per downstream buffer.
    for (genvar g = 0; g < NCH; g++) begin : g_cred
        nobl_credit_ctr #(
            .W   (CW),
            .MAX (CREDITS),
            .INIT(CREDITS)
        ) u_cred (
            .clk  (clk),
            .rst  (rst),
            .i_inc(i_dn_pop[g]),
            .i_dec(w_acc[g]),
            .o_cnt(w_cred[g]),
            .o_ovf(w_cred_ovf[g]),
            .o_unf(w_cred_unf[g])
        );
    end

    // Outstanding SRAM reads across both channels.
    nobl_credit_ctr #(
        .W   (CW),
        .MAX (MAX_INFLIGHT),
        .INIT(0)
    ) u_inflight (
        .clk  (clk),
        .rst  (rst),
        .i_inc(w_any_acc),
        .i_dec(|i_rd_valid),
        .o_cnt(w_inflight),
        .o_ovf(w_infl_ovf),
        .o_unf(w_infl_unf)
    );

    // Next-state, grant selection and gap counting.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_ISSUE;
                    if (&w_elig) begin
                        w_gnt_nxt = ~r_last_gnt;
                    end else begin
                        w_gnt_nxt = w_elig[1];
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_acc[r_gnt]) begin
                    if (GAP == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = 2'd0;
                    end
                end else if (!w_elig[r_gnt]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (int'(r_gap_cnt) + 1 >= GAP) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Scheduler registers; last_gnt moves only when a read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_gap_cnt  <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_any_acc) begin
                r_last_gnt <= r_gnt;
            end else begin
                r_last_gnt <= r_last_gnt;
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_cred_ovf) | (|w_cred_unf) | w_infl_ovf
                     | w_infl_unf | (|w_spur);
        end
    end

`ifdef NOBL_RD_SCHED_STATS_EN
    logic [31:0] r_stat_0;
    logic [31:0] r_stat_1;

    // Wrapping accepted-read counters per channel.
    always_ff @(posedge clk) begin
        if (rst || i_stat_clr) begin
            r_stat_0 <= 32'd0;
            r_stat_1 <= 32'd0;
        end else begin
            r_stat_0 <= r_stat_0 + {31'd0, w_acc[0]};
            r_stat_1 <= r_stat_1 + {31'd0, w_acc[1]};
        end
    end

    assign o_stat_rd_0 = r_stat_0;
    assign o_stat_rd_1 = r_stat_1;
`endif

    assign o_read_strobe = w_strobe;
    assign o_credits     = {w_cred[1], w_cred[0]};
    assign o_inflight    = w_inflight;
    assign o_err         = r_err;

endmodule

// File: tb/tb_nobl_rd_sched.sv
// Self-checking bench for nobl_rd_sched: randomized traffic against a
// behavioural scheduler model, plus directed scenarios for arbitration,
// in-flight limit, credit corner cases, errors and mid-operation reset.
module tb_nobl_rd_sched;

    localparam int CREDITS = 8;
    localparam int MAXI    = 6;
    localparam int GAP     = 1;
    localparam int CW      = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [1:0]      ne  = 2'b00;
    logic [1:0]      acc = 2'b00;
    logic [1:0]      val = 2'b00;
    logic [1:0]      pop = 2'b00;
    logic [1:0]      strobe;
    logic [2*CW-1:0] credits;
    logic [CW-1:0]   inflight;
    logic            err;
`ifdef NOBL_RD_SCHED_STATS_EN
    logic            stat_clr = 1'b0;
    logic [31:0]     stat0;
    logic [31:0]     stat1;
`endif

    nobl_rd_sched #(
        .CREDITS(CREDITS), .MAX_INFLIGHT(MAXI), .GAP(GAP), .CW(CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_fifo_nonempty(ne),
        .i_rd_accept    (acc),
        .i_rd_valid     (val),
        .i_dn_pop       (pop),
`ifdef NOBL_RD_SCHED_STATS_EN
        .i_stat_clr     (stat_clr),
        .o_stat_rd_0    (stat0),
        .o_stat_rd_1    (stat1),
`endif
        .o_read_strobe  (strobe),
        .o_credits      (credits),
        .o_inflight     (inflight),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (channel under strobe, remaining gap cycles).
    int m_cred [2];
    int m_infl, m_err, m_s, m_cool, m_last;
    int m_stat [2];
    int cyc = 0;
    bit g_auto_ret = 1'b0;
    int ret_t [$];
    int ret_c [$];

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cred[0] = CREDITS; m_cred[1] = CREDITS;
        m_infl = 0; m_err = 0; m_s = -1; m_cool = 0; m_last = 1;
        m_stat[0] = 0; m_stat[1] = 0;
        ret_t.delete(); ret_c.delete();
    endtask

    task automatic model_update(input bit r, input bit e, input logic [1:0] n,
                                input logic [1:0] a, input logic [1:0] v,
                                input logic [1:0] p, input bit sc);
        bit el [2];
        int ac, nc;
        if (r) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++)
            el[c] = e && n[c] && (m_cred[c] > 0) && (m_infl < MAXI);
        ac = -1;
        if (m_s >= 0) begin
            if (a[m_s]) ac = m_s;
        end
        for (int c = 0; c < 2; c++) begin
            if (p[c] && m_cred[c] == CREDITS) m_err = 1;
            if (a[c] && m_s != c) m_err = 1;
        end
        if (v != 2'b00 && m_infl == 0) m_err = 1;
        for (int c = 0; c < 2; c++) begin
            nc = m_cred[c] + int'(p[c]) - ((ac == c) ? 1 : 0);
            if (nc > CREDITS) nc = CREDITS;
            if (nc < 0) nc = 0;
            m_cred[c] = nc;
        end
        m_infl = m_infl + ((ac >= 0) ? 1 : 0) - ((v != 2'b00) ? 1 : 0);
        if (m_infl < 0) m_infl = 0;
        if (m_infl > MAXI) m_infl = MAXI;
        if (sc) begin
            m_stat[0] = 0; m_stat[1] = 0;
        end else if (ac >= 0) begin
            m_stat[ac] = m_stat[ac] + 1;
        end
        if (m_s >= 0) begin
            if (ac >= 0) begin
                m_last = ac; m_s = -1; m_cool = GAP;
            end else if (!el[m_s]) begin
                m_s = -1;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (el[0] && el[1]) begin
            m_s = 1 - m_last;
        end else if (el[0]) begin
            m_s = 0;
        end else if (el[1]) begin
            m_s = 1;
        end
    endtask

    task automatic compare();
        int exp_s;
        exp_s = (m_s < 0) ? 0 : (1 << m_s);
        chk_eq("strobe", 32'(strobe), exp_s);
        chk_eq("credits", 32'(credits), (m_cred[1] << CW) | m_cred[0]);
        chk_eq("inflight", 32'(inflight), m_infl);
        chk_eq("err", 32'(err), m_err);
`ifdef NOBL_RD_SCHED_STATS_EN
        chk_eq("stat0", stat0, m_stat[0]);
        chk_eq("stat1", stat1, m_stat[1]);
`endif
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic tick(input bit r, input bit e, input logic [1:0] n, input bit tie,
                        input logic [1:0] a, input logic [1:0] v, input logic [1:0] p,
                        input bit sc);
        logic [1:0] av, vv;
        int ac;
        av = tie ? strobe : a;
        vv = v;
        if (g_auto_ret) begin
            while (ret_t.size() > 0 && ret_t[0] <= cyc) begin
                vv[ret_c[0]] = 1'b1;
                void'(ret_t.pop_front());
                void'(ret_c.pop_front());
            end
        end
        ac = -1;
        if (!r && m_s >= 0) begin
            if (av[m_s]) ac = m_s;
        end
        if (g_auto_ret && ac >= 0) begin
            ret_t.push_back(cyc + int'($urandom_range(4, 6)));
            ret_c.push_back(ac);
        end
        rst = r; en = e; ne = n; acc = av; val = vv; pop = p;
`ifdef NOBL_RD_SCHED_STATS_EN
        stat_clr = sc;
`endif
        model_update(r, e, n, av, vv, p, sc);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        g_auto_ret = 1'b0;
        tick(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc, bound, first_ch [3], acc_cyc [$];
        logic [1:0] a, p;
        logic [1:0] n;
        bit e;
        model_reset();

        // Reset values.
        do_reset();
        do_reset();
        chk_eq("rst_credits", 32'(credits), 32'h88);
        chk_eq("rst_strobe", 32'(strobe), 0);
        chk_eq("rst_err", 32'(err), 0);

        // Randomized traffic with model-driven returns.
        g_auto_ret = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 15) != 0);
            n[0] = ($urandom_range(0, 9) < 8);
            n[1] = ($urandom_range(0, 9) < 8);
            a = 2'b00;
            if (m_s >= 0 && $urandom_range(0, 9) < 7) a[m_s] = 1'b1;
            p[0] = (m_cred[0] < CREDITS) && ($urandom_range(0, 9) < 4);
            p[1] = (m_cred[1] < CREDITS) && ($urandom_range(0, 9) < 4);
            tick(1'b0, e, n, 1'b0, a, 2'b00, p, $urandom_range(0, 199) == 0);
        end

        // Alternation, gap spacing and credit exhaustion.
        do_reset();
        g_auto_ret = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 120; i++) begin
            if (strobe != 2'b00) begin
                if (n_acc < 3) first_ch[n_acc] = strobe[1] ? 1 : 0;
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            tick(1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        chk_eq("alt_first0", first_ch[0], 0);
        chk_eq("alt_first1", first_ch[1], 1);
        chk_eq("alt_first2", first_ch[2], 0);
        chk_eq("alt_spacing", acc_cyc[1] - acc_cyc[0], 3);
        chk_eq("alt_total", n_acc, 16);
        chk_eq("alt_credits0", 32'(credits), 0);
        chk_eq("alt_strobe_stop", 32'(strobe), 0);

        // In-flight limit with no returns, then one return.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (strobe != 2'b00) n_acc++;
            tick(1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        chk_eq("infl_accepts", n_acc, 6);
        chk_eq("infl_count", 32'(inflight), 6);
        chk_eq("infl_strobe", 32'(strobe), 0);
        tick(1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (strobe != 2'b00) n_acc++;
            tick(1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        chk_eq("infl_one_more", n_acc, 7);

        // Same-cycle accept and pop on ch0 at credits = 3.
        do_reset();
        g_auto_ret = 1'b1;
        bound = 0;
        while (!(m_cred[0] == 3 && m_s == 0) && bound < 100) begin
            tick(1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
            bound++;
        end
        chk_eq("pop_acc_reach", 32'(bound < 100), 1);
        tick(1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0);
        chk_eq("pop_acc_cred", 32'(credits[CW-1:0]), 3);

        // Strobe dropped when the FIFO empties before accept.
        bound = 0;
        while (m_s != 0 && bound < 20) begin
            tick(1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
            bound++;
        end
        chk_eq("drop_strobe_up", 32'(strobe), 1);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_eq("drop_strobe", 32'(strobe), 0);
        chk_eq("drop_cred", 32'(credits[CW-1:0]), 3);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        chk_eq("drop_idle", 32'(strobe), 0);

        // Protocol errors: pop at full credits, return with nothing in flight,
        // accept without strobe.
        do_reset();
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        chk_eq("err_pop_full", 32'(err), 1);
        chk_eq("err_pop_sat", 32'(credits), 32'h88);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        chk_eq("err_val_zero", 32'(inflight), 0);
        chk_eq("err_sticky", 32'(err), 1);
        do_reset();
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        chk_eq("err_spur_acc", 32'(err), 1);
        chk_eq("err_spur_cred", 32'(credits), 32'h88);

        // Reset with reads in flight, then late returns.
        do_reset();
        bound = 0;
        while (m_infl != 4 && bound < 40) begin
            tick(1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
            bound++;
        end
        chk_eq("mid_infl4", 32'(inflight), 4);
        do_reset();
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
        chk_eq("mid_inflight", 32'(inflight), 0);
        chk_eq("mid_err", 32'(err), 1);
        chk_eq("mid_credits", 32'(credits), 32'h88);
        chk_eq("mid_strobe", 32'(strobe), 0);
`ifdef NOBL_RD_SCHED_STATS_EN
        chk_eq("mid_stat0", stat0, 0);
        chk_eq("mid_stat1", stat1, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
